// File: rtl/photon_event_capture.sv
// Photon trigger receiver: synchronizes the one-shot pulse, timestamps its rising
// edge under a dead-time window, and queues events for valid/ready readout.
module photon_event_capture #(
    parameter int TS_WIDTH    = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int DEAD_CYCLES = 2,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pulse_in,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [TS_WIDTH-1:0]           evt_timestamp,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [CNT_WIDTH-1:0]          overflow_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = (DEAD_CYCLES > 0) ? $clog2(DEAD_CYCLES + 1) : 1;
    localparam logic [DW-1:0]        DEAD_LOAD = DW'(DEAD_CYCLES);
    localparam logic [AW:0]          LVL_FULL  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

    logic [TS_WIDTH-1:0] ts_cnt;
    logic                s1, s2, s3;
    logic                fill1, fill2;
    logic                armed;
    logic [DW-1:0]       dead_cnt;
    logic [TS_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic                rise, accept, full, pop, push, drop;
    logic [AW:0]         level_nxt;

    assign rise   = s2 & ~s3 & armed;
    assign accept = rise & (dead_cnt == '0);
    assign full   = (fifo_level == LVL_FULL);
    assign pop    = evt_valid & evt_ready;
    assign push   = accept & (~full | pop);
    assign drop   = accept & full & ~pop;

    always_comb begin
        level_nxt = fifo_level;
        if (push && !pop)
            level_nxt = fifo_level + 1'b1;
        else if (pop && !push)
            level_nxt = fifo_level - 1'b1;
    end

    // The zeros left in s2 by reset are not real samples of a low pulse, so arming
    // waits until s2 has been filled from pulse_in; a level held through reset stays unarmed.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_cnt <= '0;
            s1     <= 1'b0;
            s2     <= 1'b0;
            s3     <= 1'b0;
            fill1  <= 1'b0;
            fill2  <= 1'b0;
            armed  <= 1'b0;
        end else begin
            ts_cnt <= ts_cnt + 1'b1;
            s1     <= pulse_in;
            s2     <= s1;
            s3     <= s2;
            fill1  <= 1'b1;
            fill2  <= fill1;
            armed  <= armed | (fill2 & ~s2);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            dead_cnt <= '0;
        else if (accept)
            dead_cnt <= DEAD_LOAD;
        else if (dead_cnt != '0)
            dead_cnt <= dead_cnt - 1'b1;
    end

    // Rise is seen one cycle after ts_cnt passed the sampling edge, hence the -1.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= ts_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_level     <= '0;
            evt_valid      <= 1'b0;
            overflow_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            fifo_level <= level_nxt;
            evt_valid  <= (level_nxt != '0);
            if (drop && overflow_count != CNT_MAX)
                overflow_count <= overflow_count + 1'b1;
        end
    end

    assign evt_timestamp = mem[rd_ptr];

endmodule

// File: tb/tb_photon_event_capture.sv
// Directed bench for photon_event_capture: a vector table for single-event and
// back-pressure behaviour, plus hand sequences for the multi-cycle corner cases.
module tb_photon_event_capture;

    logic clk = 1'b0;
    logic rst;
    logic pulse_in;
    logic evt_ready;

    logic        v0, v1, v2;
    logic [15:0] ts0, ts1;
    logic [3:0]  ts2;
    logic [2:0]  lvl0, lvl1, lvl2;
    logic [7:0]  ov0, ov1;
    logic [1:0]  ov2;

    always #5 clk = ~clk;

    photon_event_capture u0 (
        .clk(clk), .rst(rst), .pulse_in(pulse_in),
        .evt_valid(v0), .evt_ready(evt_ready), .evt_timestamp(ts0),
        .fifo_level(lvl0), .overflow_count(ov0)
    );

    photon_event_capture #(.DEAD_CYCLES(6)) u_dead (
        .clk(clk), .rst(rst), .pulse_in(pulse_in),
        .evt_valid(v1), .evt_ready(evt_ready), .evt_timestamp(ts1),
        .fifo_level(lvl1), .overflow_count(ov1)
    );

    photon_event_capture #(.TS_WIDTH(4), .CNT_WIDTH(2)) u_small (
        .clk(clk), .rst(rst), .pulse_in(pulse_in),
        .evt_valid(v2), .evt_ready(evt_ready), .evt_timestamp(ts2),
        .fifo_level(lvl2), .overflow_count(ov2)
    );

    int cyc;
    int n_pass;
    int n_total;

    typedef struct {
        int rst_first;
        int e;
        int p;
        int r;
        int chk;
        int v;
        int lvl;
        int ts;
        int ovf;
    } vec_t;

    vec_t vt[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, cyc, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic goto(input int k);
        while (cyc < k)
            tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic pulse_at(input int k);
        goto(k - 1);
        pulse_in = 1'b1;
        tick();
        pulse_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int exp3[4];
        n_pass    = 0;
        n_total   = 0;
        cyc       = 0;
        rst       = 1'b1;
        pulse_in  = 1'b0;
        evt_ready = 1'b0;

        // single event, then back-pressure with overflow and in-order drain
        vt.push_back('{1, 10, 1, 1, 0, 0, 0, 0, 0});
        vt.push_back('{0, 11, 0, 1, 1, 0, 0, 0, 0});
        vt.push_back('{0, 12, 0, 1, 1, 1, 1, 10, 0});
        vt.push_back('{0, 13, 0, 1, 1, 0, 0, 0, 0});
        vt.push_back('{1, 10, 1, 0, 0, 0, 0, 0, 0});
        vt.push_back('{0, 12, 0, 0, 1, 1, 1, 10, 0});
        vt.push_back('{0, 20, 1, 0, 0, 0, 0, 0, 0});
        vt.push_back('{0, 22, 0, 0, 1, 1, 2, 10, 0});
        vt.push_back('{0, 30, 1, 0, 0, 0, 0, 0, 0});
        vt.push_back('{0, 40, 1, 0, 0, 0, 0, 0, 0});
        vt.push_back('{0, 42, 0, 0, 1, 1, 4, 10, 0});
        vt.push_back('{0, 50, 1, 0, 0, 0, 0, 0, 0});
        vt.push_back('{0, 52, 0, 0, 1, 1, 4, 10, 1});
        vt.push_back('{0, 53, 0, 0, 1, 1, 4, 10, 1});
        vt.push_back('{0, 54, 0, 1, 1, 1, 3, 20, 1});
        vt.push_back('{0, 55, 0, 1, 1, 1, 2, 30, 1});
        vt.push_back('{0, 56, 0, 1, 1, 1, 1, 40, 1});
        vt.push_back('{0, 57, 0, 1, 1, 0, 0, 0, 1});

        do_reset();
        check("reset valid", 32'(v0), 0);
        check("reset timestamp", 32'(ts0), 0);
        check("reset level", 32'(lvl0), 0);
        check("reset overflow", 32'(ov0), 0);

        foreach (vt[i]) begin
            evt_ready = (vt[i].r != 0);
            pulse_in  = 1'b0;
            if (vt[i].rst_first != 0)
                do_reset();
            goto(vt[i].e - 1);
            pulse_in = (vt[i].p != 0);
            tick();
            pulse_in = 1'b0;
            if (vt[i].chk != 0) begin
                check($sformatf("vec%0d valid", i), 32'(v0), vt[i].v);
                check($sformatf("vec%0d level", i), 32'(lvl0), vt[i].lvl);
                check($sformatf("vec%0d overflow", i), 32'(ov0), vt[i].ovf);
                if (vt[i].v != 0)
                    check($sformatf("vec%0d timestamp", i), 32'(ts0), vt[i].ts);
            end
        end

        // full FIFO: a push landing on the same edge as a pop is kept
        evt_ready = 1'b0;
        do_reset();
        pulse_at(10);
        pulse_at(20);
        pulse_at(30);
        pulse_at(40);
        pulse_at(50);
        goto(51);
        check("full before pop level", 32'(lvl0), 4);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        check("full+pop level", 32'(lvl0), 4);
        check("full+pop overflow", 32'(ov0), 0);
        check("full+pop head", 32'(ts0), 20);
        tick();
        check("full+pop level held", 32'(lvl0), 4);
        exp3 = '{20, 30, 40, 50};
        for (int j = 0; j < 4; j++) begin
            check($sformatf("full+pop drain%0d", j), 32'(ts0), exp3[j]);
            evt_ready = 1'b1;
            tick();
        end
        evt_ready = 1'b0;
        check("full+pop drained valid", 32'(v0), 0);
        check("full+pop drained level", 32'(lvl0), 0);

        // dead time of 6: the pulse at 14 falls inside the window, 17 just clears it
        do_reset();
        pulse_at(10);
        pulse_at(14);
        pulse_at(17);
        goto(20);
        check("dead level", 32'(lvl1), 2);
        check("dead overflow", 32'(ov1), 0);
        check("dead head first", 32'(ts1), 10);
        evt_ready = 1'b1;
        tick();
        check("dead head second", 32'(ts1), 17);
        check("dead level after pop", 32'(lvl1), 1);
        tick();
        check("dead drained valid", 32'(v1), 0);
        evt_ready = 1'b0;

        // 4-bit timestamp wrap and 2-bit saturating overflow counter
        do_reset();
        pulse_at(17);
        goto(19);
        check("wrap valid", 32'(v2), 1);
        check("wrap timestamp", 32'(ts2), 1);
        for (int n = 1; n <= 4; n++)
            pulse_at(17 + 3 * n);
        goto(31);
        check("sat overflow after 1 drop", 32'(ov2), 1);
        for (int n = 5; n <= 9; n++)
            pulse_at(17 + 3 * n);
        goto(46);
        check("sat overflow after 6 drops", 32'(ov2), 3);
        check("sat level", 32'(lvl2), 4);
        check("sat head", 32'(ts2), 1);

        // pulse held high through reset release must not produce an event
        pulse_in = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        cyc = 0;
        goto(5);
        pulse_in = 1'b0;
        goto(12);
        check("held-high valid", 32'(v0), 0);
        check("held-high level", 32'(lvl0), 0);
        pulse_at(20);
        pulse_at(30);
        pulse_at(40);
        goto(42);
        check("queued level", 32'(lvl0), 3);
        check("queued head", 32'(ts0), 20);
        rst = 1'b1;
        tick();
        check("mid reset valid", 32'(v0), 0);
        check("mid reset level", 32'(lvl0), 0);
        check("mid reset timestamp", 32'(ts0), 0);
        rst = 1'b0;
        cyc = 0;

        // a rise in flight when reset hits is lost
        pulse_at(10);
        goto(11);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cyc = 0;
        goto(6);
        check("in-flight lost level", 32'(lvl0), 0);
        check("in-flight lost valid", 32'(v0), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
